// File: rtl/fp_accumulate_dump.sv
// Fixed-point accumulate-and-dump stage: sums a programmable number of signed
// products, saturates, and dumps a requantized frame sum with an overflow flag.
module fp_accumulate_dump #(
  parameter int WII  = 7,
  parameter int WFI  = 7,
  parameter int WG   = 4,
  parameter int WIO  = 8,
  parameter int WFO  = 4,
  parameter int LENW = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [LENW-1:0]             frameLen,
  input  logic                        inValid,
  input  logic signed [WII+WFI-1:0]   in,
  input  logic                        inOvf,
  output logic                        busy,
  output logic                        outValid,
  output logic signed [WIO+WFO-1:0]   accOut,
  output logic                        overFlow
);

  localparam int WI = WII + WFI;
  localparam int WA = WII + WG + WFI;
  localparam int WO = WIO + WFO;
  localparam int WT = WA + WFO;
  localparam logic [LENW-1:0] LEN_ONE  = {{(LENW-1){1'b0}}, 1'b1};
  localparam logic [LENW-1:0] LEN_ZERO = {LENW{1'b0}};

  typedef enum logic [0:0] {IDLE = 1'b0, ACC = 1'b1} state_t;

  // Returns {sat, value}: the one-bit-wider sum clamped back into WA bits.
  function automatic logic [WA:0] sat_acc(input logic [WA:0] s);
    logic [WA:0] r;
    if (s[WA] != s[WA-1]) r = {1'b1, s[WA], {(WA-1){~s[WA]}}};
    else                  r = {1'b0, s[WA-1:0]};
    return r;
  endfunction

  // Returns {sat, value}: floor-requantize WFI -> WFO fraction bits, then clamp to WO bits.
  function automatic logic [WO:0] requant(input logic [WA-1:0] a);
    logic signed [WT-1:0] t;
    logic [WO:0]          r;
    t = $signed({a, {WFO{1'b0}}}) >>> WFI;
    if (t[WT-1:WO-1] != {(WT-WO+1){t[WT-1]}}) r = {1'b1, t[WT-1], {(WO-1){~t[WT-1]}}};
    else                                      r = {1'b0, t[WO-1:0]};
    return r;
  endfunction

  state_t          state_r, state_s;
  logic [WA-1:0]   acc_r, acc_s;
  logic [LENW-1:0] count_r, count_s;
  logic            sticky_r, sticky_s;
  logic [WO-1:0]   accout_r, accout_s;
  logic            ovf_r, ovf_s;
  logic            outvalid_r, outvalid_s;

  logic [WA:0]     sum_s;
  logic [WA:0]     accsat_s;
  logic [WO:0]     rq_s;
  logic            last_s;
  logic            restart_s;

  // Datapath: saturating add of the incoming product and requantization of the result.
  always_comb begin
    sum_s    = {acc_r[WA-1], acc_r} + {{(WA+1-WI){in[WI-1]}}, in};
    accsat_s = sat_acc(sum_s);
    rq_s     = requant(accsat_s[WA-1:0]);
    last_s   = inValid && (count_r == LEN_ONE);
    restart_s = start && (frameLen != LEN_ZERO);
  end

  // Next-state and next-output logic for the IDLE/ACC controller.
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    count_s    = count_r;
    sticky_s   = sticky_r;
    accout_s   = accout_r;
    ovf_s      = ovf_r;
    outvalid_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (restart_s) begin
          state_s  = ACC;
          acc_s    = {WA{1'b0}};
          count_s  = frameLen;
          sticky_s = 1'b0;
        end else begin
          state_s = IDLE;
        end
      end
      ACC: begin
        if (last_s) begin
          accout_s   = rq_s[WO-1:0];
          ovf_s      = sticky_r | inOvf | accsat_s[WA] | rq_s[WO];
          outvalid_s = 1'b1;
          // A start on the last sample chains straight into the next frame.
          state_s    = restart_s ? ACC : IDLE;
          acc_s      = {WA{1'b0}};
          count_s    = restart_s ? frameLen : LEN_ZERO;
          sticky_s   = 1'b0;
        end else if (start) begin
          state_s  = restart_s ? ACC : IDLE;
          acc_s    = {WA{1'b0}};
          count_s  = restart_s ? frameLen : LEN_ZERO;
          sticky_s = 1'b0;
        end else if (inValid) begin
          acc_s    = accsat_s[WA-1:0];
          sticky_s = sticky_r | inOvf | accsat_s[WA];
          count_s  = count_r - LEN_ONE;
        end else begin
          state_s = ACC;
        end
      end
      default: begin
        state_s  = IDLE;
        acc_s    = {WA{1'b0}};
        count_s  = LEN_ZERO;
        sticky_s = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      acc_r      <= {WA{1'b0}};
      count_r    <= LEN_ZERO;
      sticky_r   <= 1'b0;
      accout_r   <= {WO{1'b0}};
      ovf_r      <= 1'b0;
      outvalid_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      count_r    <= count_s;
      sticky_r   <= sticky_s;
      accout_r   <= accout_s;
      ovf_r      <= ovf_s;
      outvalid_r <= outvalid_s;
    end
  end

  assign busy     = (state_r == ACC);
  assign outValid = outvalid_r;
  assign accOut   = $signed(accout_r);
  assign overFlow = ovf_r;

endmodule

// File: doc/fp_accumulate_dump.md
Name: fp_accumulate_dump

Overview:
- Fixed-point accumulate-and-dump stage placed directly downstream of the pipelined fixed-point multiplier.
- Sums a programmable number of signed products carrying the multiplier's overflow flag.
- Saturates on accumulator or output overflow.
- Presents the requantized frame sum with a one-cycle valid pulse and a per-frame overflow flag.

Parameters:
- WII, 7, input integer length (matches multiplier output).
- WFI, 7, input fraction length.
- WG, 4, accumulator guard bits. Accumulator is WII+WG integer bits by WFI fraction bits.
- WIO, 8, output integer length.
- WFO, 4, output fraction length.
- LENW, 8, width of the frame-length input.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- start, input, 1, begin frame; samples frameLen.
- frameLen, input, LENW, samples per frame; 0 means start is ignored.
- inValid, input, 1, the in/inOvf pair is valid this cycle.
- in, input signed, WII+WFI, product sample.
- inOvf, input, 1, multiplier overflow flag aligned with in.
- busy, output, 1, high while in ACC.
- outValid, output, 1, one-cycle pulse when a frame result is updated.
- accOut, output signed, WIO+WFO, frame sum; holds until the next dump.
- overFlow, output, 1, frame overflow status; updated together with accOut and held.

Behaviour:
- Reset (async, rst=1): state IDLE, acc=0, count=0, busy=0, outValid=0, accOut=0, overFlow=0, sticky=0. Reset mid-frame discards the frame and produces no outValid.
- FSM states: IDLE and ACC.
  - IDLE, start=1, frameLen!=0: go to ACC; acc=0; count=frameLen; sticky=0.
  - IDLE, inValid: ignored.
  - IDLE, start with frameLen=0: ignored.
  - A sample presented in the same cycle as a start from IDLE is not counted.
- ACC, inValid=1:
  - acc_next = sat_acc(acc + sign_extend(in)).
  - sticky |= inOvf | acc_sat.
  - count decrements.
  - inValid=0 cycles (gaps) leave all state unchanged.
- Last sample (count==1 and inValid), at that same edge:
  - accOut = requant(acc_next).
  - overFlow = sticky | inOvf | acc_sat | out_sat.
  - outValid=1 for exactly the following cycle.
  - State returns to IDLE.
  - Latency: result visible one cycle after the clock edge that samples the last sample.
- start while in ACC, not on the last sample: abort. Partial sum is discarded, no outValid, frame restarts with the new frameLen (0 means go to IDLE).
- start on the last-sample cycle: the current frame completes normally (outValid next cycle) and a new frame begins with acc=0, sticky=0, count=frameLen. This gives back-to-back frames with no gap. If frameLen=0, go to IDLE.
- sat_acc: clamp to [-2^(WII+WG-1), 2^(WII+WG-1)-2^-WFI]. Clamping sets acc_sat.
- requant:
  - If WFO<WFI: arithmetic drop of WFI-WFO LSBs (truncate toward -inf).
  - If WFO>WFI: zero-pad.
  - Then clamp to [-2^(WIO-1), 2^(WIO-1)-2^-WFO]; clamping sets out_sat.
  - No rounding.
- overFlow is not sticky across frames; each dump overwrites it.
- busy=1 exactly while the state is ACC.

Test Plan:
- Basic sum: frameLen=4; in = 0x0080, 0x0140, 0x3FC0, 0x0020 (1.0, 2.5, -0.5, 0.25) with one idle gap between samples 2 and 3.
  - Expect accOut=0x034 (3.25) one cycle after the 4th sample.
  - outValid high for exactly one cycle, overFlow=0, busy low afterwards.
- Output saturation: frameLen=3; in=0x1E00 (60.0) three times.
  - Expect accOut=0x7FF and overFlow=1.
  - Repeat with -60.0 (0x2200): expect accOut=0x800 and overFlow=1.
- Accumulator saturation: frameLen=255; in=0x1F80 (63.0) continuously.
  - acc clamps at 1023.9921875; expect accOut=0x7FF and overFlow=1.
  - Next frame of frameLen=1, in=0x0080: expect accOut=0x010 and overFlow=0.
- Truncation and inOvf:
  - frameLen=1, in=0x3FFF (-2^-7): expect accOut=0xFFF (-0.0625).
  - frameLen=2 with inOvf=1 on the first sample and a small sum: expect overFlow=1.
- Abort and back-to-back:
  - frameLen=4, two samples of 1.0, then start with frameLen=2, then 2.0 and 2.0: expect exactly one outValid, with accOut=0x040.
  - start asserted on a last-sample cycle: two outValid pulses exactly frameLen valid cycles apart, with no lost samples.
- Reset mid-frame: assert rst after 2 of 4 samples.
  - All outputs go to 0 asynchronously with no outValid.
  - After release, a fresh frame accumulates from 0.
